decode_stage: RTL and testbench

RV32I instruction decode stage with ID/EX pipeline register. It accepts an instruction from fetch, drives the regfile read addresses and takes back the read data. It bypasses same-cycle writeback data, generates the immediate and control signals, and detects load-use hazards. Results are registered toward execute under a valid/ready handshake, and a flush input is honoured for branch redirects.

---
 rtl/rv32i_pkg.sv | 74 +++++++
 rtl/imm_gen.sv | 33 +++
 rtl/decode_stage.sv | 204 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// RV32I decode definitions: opcodes, ALU operation and immediate-type
// encodings, and the per-instruction control bundle.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    typedef struct packed {
        imm_type_e imm_type;
        alu_op_e   alu_op;
        logic      alu_src_imm;
        logic      mem_read;
        logic      mem_write;
        logic      reg_wen;
        logic      branch;
        logic      jump;
        logic      illegal;
        logic      rs1_used;
        logic      rs2_used;
    } ctrl_t;

    // Register-register ops use bit 30 to select SUB; immediate ops
    // only use it to pick the arithmetic right shift.
    function automatic alu_op_e alu_dec(
        input logic [2:0] funct3,
        input logic       alt,
        input logic       reg_op
    );
        alu_op_e op;
        op = ALU_ADD;
        unique case (funct3)
            3'b000: op = (alt && reg_op) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I/S/B/U/J immediate of instr.
// Ports: instr (instruction word), imm_type (imm_type_e), imm (32-bit).
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [2:0]  imm_type,
    output logic [31:0] imm
);

    logic sign;
    logic unused_opcode;

    assign sign = instr[31];

    // Opcode bits carry no immediate data.
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm = {{20{sign}}, instr[31:20]};
        unique case (imm_type)
            IMM_I: imm = {{20{sign}}, instr[31:20]};
            IMM_S: imm = {{20{sign}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{sign}}, sign, instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{sign}}, sign, instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = {{20{sign}}, instr[31:20]};
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with ID/EX register, writeback bypass, load-use
// stall and flush. Ports: fetch handshake (if_*), regfile read
// (rs*_addr/rs*_data), writeback bypass (wb_*), flush, and the
// registered execute bundle (ex_*) under ex_valid/ex_ready.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1_addr,
    output logic [4:0]      ex_rs2_addr,
    output logic [2:0]      ex_funct3,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src_imm,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_wen,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    ctrl_t           ctrl;
    logic [31:0]     imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            load_pending;
    logic            hazard;
    logic            adv;

    assign opcode   = if_instr[6:0];
    assign rd       = if_instr[11:7];
    assign funct3   = if_instr[14:12];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    always_comb begin
        ctrl          = '0;
        ctrl.imm_type = IMM_I;
        ctrl.alu_op   = ALU_ADD;
        unique case (1'b1)
            opcode == OPC_LUI: begin
                ctrl.imm_type    = IMM_U;
                ctrl.alu_op      = ALU_PASSB;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_wen     = 1'b1;
            end
            opcode == OPC_AUIPC: begin
                ctrl.imm_type    = IMM_U;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_wen     = 1'b1;
            end
            opcode == OPC_JAL: begin
                ctrl.imm_type = IMM_J;
                ctrl.jump     = 1'b1;
                ctrl.reg_wen  = 1'b1;
            end
            opcode == OPC_JALR: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.jump        = 1'b1;
                ctrl.reg_wen     = 1'b1;
                ctrl.rs1_used    = 1'b1;
            end
            opcode == OPC_BRANCH: begin
                ctrl.imm_type = IMM_B;
                ctrl.alu_op   = ALU_SUB;
                ctrl.branch   = 1'b1;
                ctrl.rs1_used = 1'b1;
                ctrl.rs2_used = 1'b1;
            end
            opcode == OPC_LOAD: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_read    = 1'b1;
                ctrl.reg_wen     = 1'b1;
                ctrl.rs1_used    = 1'b1;
            end
            opcode == OPC_STORE: begin
                ctrl.imm_type    = IMM_S;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
                ctrl.rs1_used    = 1'b1;
                ctrl.rs2_used    = 1'b1;
            end
            opcode == OPC_OP_IMM: begin
                ctrl.alu_op      = alu_dec(funct3, if_instr[30], 1'b0);
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_wen     = 1'b1;
                ctrl.rs1_used    = 1'b1;
            end
            opcode == OPC_OP: begin
                ctrl.alu_op   = alu_dec(funct3, if_instr[30], 1'b1);
                ctrl.reg_wen  = 1'b1;
                ctrl.rs1_used = 1'b1;
                ctrl.rs2_used = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
        if (rd == 5'd0) ctrl.reg_wen = 1'b0;
    end

    imm_gen u_imm_gen (
        .instr    (if_instr),
        .imm_type (ctrl.imm_type),
        .imm      (imm)
    );

    // The regfile write lands at the same edge we capture, so a
    // matching writeback must be forwarded; x0 is hardwired to zero.
    always_comb begin
        rs1_val = rs1_data;
        if (rs1_addr == 5'd0)
            rs1_val = '0;
        else if (wb_wen && wb_rd == rs1_addr)
            rs1_val = wb_data;
    end

    always_comb begin
        rs2_val = rs2_data;
        if (rs2_addr == 5'd0)
            rs2_val = '0;
        else if (wb_wen && wb_rd == rs2_addr)
            rs2_val = wb_data;
    end

    // Load data is not available until after EX; only sources the
    // instruction actually reads can create a stall.
    assign load_pending = ex_valid && ex_mem_read && (ex_rd != 5'd0);
    assign hazard = load_pending &&
                    ((ctrl.rs1_used && ex_rd == rs1_addr) ||
                     (ctrl.rs2_used && ex_rd == rs2_addr));

    assign adv      = !ex_valid || ex_ready;
    assign if_ready = flush || (adv && !hazard);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_pc          <= RESET_PC;
            ex_rs1_val     <= '0;
            ex_rs2_val     <= '0;
            ex_imm         <= '0;
            ex_rd          <= '0;
            ex_rs1_addr    <= '0;
            ex_rs2_addr    <= '0;
            ex_funct3      <= '0;
            ex_alu_op      <= '0;
            ex_alu_src_imm <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_reg_wen     <= 1'b0;
            ex_branch      <= 1'b0;
            ex_jump        <= 1'b0;
            ex_illegal     <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (adv) begin
            ex_valid <= if_valid && !hazard;
            if (if_valid && !hazard) begin
                ex_pc          <= if_pc;
                ex_rs1_val     <= rs1_val;
                ex_rs2_val     <= rs2_val;
                ex_imm         <= imm;
                ex_rd          <= rd;
                ex_rs1_addr    <= rs1_addr;
                ex_rs2_addr    <= rs2_addr;
                ex_funct3      <= funct3;
                ex_alu_op      <= ctrl.alu_op;
                ex_alu_src_imm <= ctrl.alu_src_imm;
                ex_mem_read    <= ctrl.mem_read;
                ex_mem_write   <= ctrl.mem_write;
                ex_reg_wen     <= ctrl.reg_wen;
                ex_branch      <= ctrl.branch;
                ex_jump        <= ctrl.jump;
                ex_illegal     <= ctrl.illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios then random
// traffic, checked against a behavioural decode model.
module tb_decode_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n, if_valid, if_ready, wb_wen, flush, ex_ready;
    logic [31:0] if_pc, if_instr, rs1_data, rs2_data, wb_data;
    logic [4:0]  rs1_addr, rs2_addr, wb_rd;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd, ex_rs1_addr, ex_rs2_addr;
    logic [2:0]  ex_funct3;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src_imm, ex_mem_read, ex_mem_write;
    logic        ex_reg_wen, ex_branch, ex_jump, ex_illegal;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_rs1_addr(ex_rs1_addr),
        .ex_rs2_addr(ex_rs2_addr), .ex_funct3(ex_funct3),
        .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_wen(ex_reg_wen), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    typedef struct packed {
        logic [31:0] pc, rs1v, rs2v, imm;
        logic [4:0]  rd, rs1a, rs2a;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic src_imm, mr, mw, rwen, br, jmp, ill;
    } rec_t;

    rec_t        q[$];
    rec_t        in_ex;
    bit          in_ex_v = 0;
    bit          mon_en = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pc_ctr = 32'h100;
    rec_t        mon_a, mon_e;

    task automatic check(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sx(logic [31:0] v, int bits);
        int sh;
        sh = 32 - bits;
        return 32'($signed(v << sh) >>> sh);
    endfunction

    function automatic logic [31:0] opnd(logic [4:0] r, logic [31:0] d,
                                         logic wen, logic [4:0] wrd,
                                         logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (wen && wrd == r) return wd;
        return d;
    endfunction

    function automatic logic [3:0] alu_of(logic [2:0] f3, logic sub, logic sra);
        alu_op_e base[8];
        base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                 ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (f3 == 3'd0 && sub) return ALU_SUB;
        if (f3 == 3'd5 && sra) return ALU_SRA;
        return base[f3];
    endfunction

    function automatic rec_t model(logic [31:0] pc, logic [31:0] ins,
                                   logic [31:0] d1, logic [31:0] d2,
                                   logic wen, logic [4:0] wrd,
                                   logic [31:0] wd);
        rec_t r;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        i_imm = sx(32'(ins[31:20]), 12);
        s_imm = sx({20'b0, ins[31:25], ins[11:7]}, 12);
        b_imm = sx({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        u_imm = ins & 32'hFFFF_F000;
        j_imm = sx({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        r = '0;
        r.pc = pc;
        r.rd = ins[11:7];
        r.rs1a = ins[19:15];
        r.rs2a = ins[24:20];
        r.f3 = ins[14:12];
        r.rs1v = opnd(ins[19:15], d1, wen, wrd, wd);
        r.rs2v = opnd(ins[24:20], d2, wen, wrd, wd);
        r.alu = ALU_ADD;
        r.imm = i_imm;
        case (ins[6:0])
            OPC_LUI:    begin r.imm = u_imm; r.alu = ALU_PASSB;
                              r.src_imm = 1; r.rwen = 1; end
            OPC_AUIPC:  begin r.imm = u_imm; r.src_imm = 1; r.rwen = 1; end
            OPC_JAL:    begin r.imm = j_imm; r.jmp = 1; r.rwen = 1; end
            OPC_JALR:   begin r.jmp = 1; r.rwen = 1; r.src_imm = 1; end
            OPC_BRANCH: begin r.imm = b_imm; r.br = 1; r.alu = ALU_SUB; end
            OPC_LOAD:   begin r.mr = 1; r.rwen = 1; r.src_imm = 1; end
            OPC_STORE:  begin r.imm = s_imm; r.mw = 1; r.src_imm = 1; end
            OPC_OP_IMM: begin r.src_imm = 1; r.rwen = 1;
                              r.alu = alu_of(ins[14:12], 1'b0, ins[30]); end
            OPC_OP:     begin r.rwen = 1;
                              r.alu = alu_of(ins[14:12], ins[30], ins[30]); end
            default:    r.ill = 1;
        endcase
        if (r.rd == 5'd0) r.rwen = 0;
        return r;
    endfunction

    function automatic bit uses1(logic [6:0] o);
        return o inside {OPC_JALR, OPC_BRANCH, OPC_LOAD,
                         OPC_STORE, OPC_OP_IMM, OPC_OP};
    endfunction

    function automatic bit uses2(logic [6:0] o);
        return o inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    endfunction

    task automatic cyc(logic r, logic v, logic [31:0] ins, logic rdy,
                       logic fl, logic [31:0] d1, logic [31:0] d2,
                       logic wen, logic [4:0] wrd, logic [31:0] wd);
        rec_t e;
        bit hz, adv, exp_rdy;
        @(posedge clk);
        #1;
        rst_n = r; if_valid = v; if_instr = ins; if_pc = pc_ctr;
        ex_ready = rdy; flush = fl; rs1_data = d1; rs2_data = d2;
        wb_wen = wen; wb_rd = wrd; wb_data = wd;
        @(negedge clk);
        #1;
        e = model(pc_ctr, ins, d1, d2, wen, wrd, wd);
        hz = in_ex_v && in_ex.mr && in_ex.rd != 5'd0 &&
             ((uses1(ins[6:0]) && in_ex.rd == ins[19:15]) ||
              (uses2(ins[6:0]) && in_ex.rd == ins[24:20]));
        adv = !in_ex_v || rdy;
        exp_rdy = fl || (adv && !hz);
        if (r && mon_en) begin
            check("if_ready", if_ready, exp_rdy);
            check("rs_addr", {rs1_addr, rs2_addr}, {ins[19:15], ins[24:20]});
        end
        if (!r) begin
            in_ex_v = 0;
            q.delete();
        end else if (fl) begin
            in_ex_v = 0;
        end else if (adv) begin
            if (v && exp_rdy) begin
                in_ex = e;
                in_ex_v = 1;
                q.push_back(e);
            end else begin
                in_ex_v = 0;
            end
        end
        pc_ctr += 4;
    endtask

    task automatic drv(logic r, logic v, logic [31:0] ins, logic rdy, logic fl);
        cyc(r, v, ins, rdy, fl, $urandom, $urandom, 1'($urandom),
            5'($urandom_range(0, 3)), $urandom);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0]  opcs[10];
        logic [31:0] ins;
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                 OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, 7'b0001111};
        ins = $urandom;
        ins[6:0] = opcs[$urandom_range(0, 9)];
        ins[11:7] = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("ex_valid", ex_valid, q.size() != 0);
            if (rst_n && ex_valid && q.size() != 0) begin
                mon_a = '{ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd,
                          ex_rs1_addr, ex_rs2_addr, ex_funct3, ex_alu_op,
                          ex_alu_src_imm, ex_mem_read, ex_mem_write,
                          ex_reg_wen, ex_branch, ex_jump, ex_illegal};
                mon_e = q[0];
                if (mon_e.ill) begin
                    mon_a.imm = '0; mon_e.imm = '0;
                    mon_a.alu = '0; mon_e.alu = '0;
                end
                check("ex_bundle", mon_a, mon_e);
                if (flush || ex_ready) void'(q.pop_front());
            end
        end
    end

    localparam logic [31:0] ADDI1 = 32'h0050_0093;
    localparam logic [31:0] ADDI2 = 32'h00A0_0113;
    localparam logic [31:0] ADD31 = 32'h0000_81B3;
    localparam logic [31:0] LW    = 32'h0000_A103;
    localparam logic [31:0] ADDLU = 32'h0011_01B3;

    initial begin
        rst_n = 0; if_valid = 0; if_instr = 0; if_pc = 0; ex_ready = 0;
        flush = 0; rs1_data = 0; rs2_data = 0; wb_wen = 0; wb_rd = 0;
        wb_data = 0;
        drv(0, 0, 0, 1, 0);
        drv(0, 1, ADDI1, 1, 0);
        check("reset_valid", ex_valid, 1'b0);
        check("reset_pc", ex_pc, RST_PC);
        check("reset_data", {ex_rs1_val, ex_rs2_val, ex_imm, ex_rd,
                             ex_rs1_addr, ex_rs2_addr, ex_funct3,
                             ex_alu_op, ex_alu_src_imm, ex_mem_read,
                             ex_mem_write, ex_reg_wen, ex_branch,
                             ex_jump, ex_illegal}, 256'd0);
        mon_en = 1;
        drv(1, 1, ADDI1, 1, 0);
        drv(1, 0, 0, 1, 0);
        cyc(1, 1, ADD31, 1, 0, 32'h11, 32'h5, 1, 5'd1, 32'hAA);
        cyc(1, 1, ADD31, 1, 0, 32'h11, 32'h5, 1, 5'd0, 32'hAA);
        drv(1, 0, 0, 1, 0);
        drv(1, 1, LW, 1, 0);
        drv(1, 1, ADDLU, 1, 0);
        drv(1, 1, ADDLU, 1, 0);
        drv(1, 0, 0, 1, 0);
        drv(1, 1, ADDI1, 1, 0);
        for (int i = 0; i < 3; i++) drv(1, 1, ADDI2, 0, 0);
        drv(1, 1, ADDI2, 1, 0);
        drv(1, 0, 0, 1, 0);
        drv(1, 1, LW, 1, 0);
        drv(1, 1, ADDLU, 1, 1);
        drv(1, 0, 0, 1, 0);
        drv(1, 0, 0, 1, 0);
        drv(1, 1, 32'hFFFF_FFFF, 1, 0);
        drv(1, 1, ADDI1, 1, 0);
        drv(0, 1, ADDI2, 1, 0);
        drv(1, 0, 0, 1, 0);
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                rnd_instr(), $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0, $urandom, $urandom,
                1'($urandom), 5'($urandom_range(0, 3)), $urandom);
        end
        for (int i = 0; i < 3; i++) drv(1, 0, 0, 1, 0);
        check("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
